// File: rtl/arb_muxn_pkg.sv
// arb_pkg: shared mode constants and round-robin pointer wrap for arb_muxn
package arb_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int ptr_inc(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/arb_muxn_if.sv
// arb_muxn_if: producer/consumer handshake bundle for the N-channel word mux
interface arb_muxn_if #(parameter int WORD_SIZE = 16, parameter int N = 4);
  localparam int SEL_W = $clog2(N);
  logic [N*WORD_SIZE-1:0] d;
  logic [N-1:0] d_valid;
  logic [N-1:0] d_ready;
  logic mode;
  logic [SEL_W-1:0] s;
  logic [WORD_SIZE-1:0] y;
  logic y_valid;
  logic y_ready;
  logic [SEL_W-1:0] y_src;
  modport master(output d, d_valid, mode, s, y_ready, input d_ready, y, y_valid, y_src);
  modport slave(input d, d_valid, mode, s, y_ready, output d_ready, y, y_valid, y_src);
endinterface

// File: rtl/arb_muxn_rr_pick.sv
// rr_pick: round-robin one-hot pick via rotate, lowest-set-bit, un-rotate
module rr_pick #(
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);
  logic [2*N-1:0] rot_w, unrot_w;
  logic [N-1:0] rot, pick;
  always_comb begin
    rot_w = {req, req} >> ptr;
    rot = rot_w[N-1:0];
    pick = rot & -rot;
    unrot_w = {pick, pick} << ptr;
    gnt = unrot_w[2*N-1:N];
    any = |req;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) gnt_idx = gnt[i] ? SEL_W'(i) : gnt_idx;
  end
endmodule

// File: rtl/arb_muxn.sv
// arb_muxn: registered N-channel word mux with fixed-select and round-robin modes
module arb_muxn
  import arb_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input logic clk,
  input logic reset,
  arb_muxn_if.slave bus
);
  logic [WORD_SIZE-1:0] y_q, y_d;
  logic [SEL_W-1:0] src_q, src_d, ptr_q, ptr_d, rr_idx, g;
  logic vld_q, vld_d, rr_any, any, load_en, xfer;
  logic [N-1:0] rr_gnt, fx_gnt, gnt;
  logic [N-1:0][WORD_SIZE-1:0] words;
  rr_pick #(.N(N)) u_pick (
    .req(bus.d_valid),
    .ptr(ptr_q),
    .gnt(rr_gnt),
    .gnt_idx(rr_idx),
    .any(rr_any)
  );
  always_comb begin
    words = bus.d;
    fx_gnt = '0;
    for (int i = 0; i < N; i++) fx_gnt[i] = (bus.s == SEL_W'(i)) && bus.d_valid[i];
    gnt = (bus.mode == MODE_RR) ? rr_gnt : fx_gnt;
    any = (bus.mode == MODE_RR) ? rr_any : |fx_gnt;
    g = (bus.mode == MODE_RR) ? rr_idx : bus.s;
    load_en = !vld_q || bus.y_ready;
    xfer = load_en && any;
    y_d = xfer ? words[g] : y_q;
    src_d = xfer ? g : src_q;
    vld_d = load_en ? xfer : vld_q;
    ptr_d = (xfer && bus.mode == MODE_RR) ? SEL_W'(ptr_inc(int'(g), N)) : ptr_q;
    bus.d_ready = (load_en && !reset) ? gnt : '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      y_q <= '0;
      src_q <= '0;
      vld_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      y_q <= y_d;
      src_q <= src_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  assign bus.y = y_q;
  assign bus.y_src = src_q;
  assign bus.y_valid = vld_q;
endmodule

// File: tb/tb_arb_muxn.sv
// tb_arb_muxn: directed and random checks of arb_muxn (N=4 and N=3) against a reference model
module tb_arb_muxn;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [3:0][15:0] dd[2];
  logic [3:0] dv[2];
  logic md[2];
  logic [1:0] ss[2];
  logic yr[2];
  logic [3:0] o_dr[2];
  logic [15:0] o_y[2];
  logic [1:0] o_src[2];
  logic o_v[2];
  logic [15:0] m_y[2];
  int m_src[2], m_ptr[2];
  logic m_v[2];
  int total = 0, bad = 0;
  arb_muxn_if #(.WORD_SIZE(16), .N(4)) b4();
  arb_muxn_if #(.WORD_SIZE(16), .N(3)) b3();
  assign b4.d = dd[0];
  assign b4.d_valid = dv[0];
  assign b4.mode = md[0];
  assign b4.s = ss[0];
  assign b4.y_ready = yr[0];
  assign b3.d = {dd[1][2], dd[1][1], dd[1][0]};
  assign b3.d_valid = dv[1][2:0];
  assign b3.mode = md[1];
  assign b3.s = ss[1];
  assign b3.y_ready = yr[1];
  assign o_dr[0] = b4.d_ready;
  assign o_dr[1] = {1'b0, b3.d_ready};
  assign o_y[0] = b4.y;
  assign o_y[1] = b3.y;
  assign o_src[0] = b4.y_src;
  assign o_src[1] = b3.y_src;
  assign o_v[0] = b4.y_valid;
  assign o_v[1] = b3.y_valid;
  arb_muxn #(.WORD_SIZE(16), .N(4)) u4 (.clk(clk), .reset(rst), .bus(b4));
  arb_muxn #(.WORD_SIZE(16), .N(3)) u3 (.clk(clk), .reset(rst), .bus(b3));
  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s dut%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask
  function automatic logic [3:0] exp_ready(input int k);
    int n;
    int g;
    logic [3:0] r;
    n = (k == 0) ? 4 : 3;
    g = -1;
    r = '0;
    if (rst || (m_v[k] && !yr[k])) return r;
    if (!md[k]) begin
      if (int'(ss[k]) < n && dv[k][ss[k]]) g = int'(ss[k]);
    end else
      for (int j = 0; j < n; j++)
        if (g < 0 && dv[k][(m_ptr[k] + j) % n]) g = (m_ptr[k] + j) % n;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction
  task automatic cyc();
    logic [3:0] er[2];
    int n;
    int g;
    #1;
    for (int k = 0; k < 2; k++) begin
      er[k] = exp_ready(k);
      chk("d_ready", k, 32'(o_dr[k]), 32'(er[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      g = -1;
      for (int j = 0; j < 4; j++) if (er[k][j]) g = j;
      if (rst) begin
        m_y[k] = '0;
        m_src[k] = 0;
        m_v[k] = 1'b0;
        m_ptr[k] = 0;
      end else if (!m_v[k] || yr[k]) begin
        if (g >= 0) begin
          m_y[k] = dd[k][g];
          m_src[k] = g;
          m_v[k] = 1'b1;
          if (md[k]) m_ptr[k] = (g + 1) % n;
        end else m_v[k] = 1'b0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("y_valid", k, 32'(o_v[k]), 32'(m_v[k]));
      chk("y", k, 32'(o_y[k]), 32'(m_y[k]));
      chk("y_src", k, 32'(o_src[k]), m_src[k]);
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) dd[k][i] = 16'h1000 + 16'(i);
      dv[k] = '0;
      md[k] = 1'b0;
      ss[k] = 2'd0;
      yr[k] = 1'b1;
      m_y[k] = '0;
      m_src[k] = 0;
      m_ptr[k] = 0;
      m_v[k] = 1'b0;
    end
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_valid", 0, 32'(o_v[0]), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      md[k] = 1'b0;
      ss[k] = 2'd2;
      dv[k] = 4'hf;
    end
    #1;
    chk("fixed_ready", 0, 32'(o_dr[0]), 32'h4);
    cyc();
    chk("fixed_y", 0, 32'(o_y[0]), 32'h1002);
    chk("fixed_src", 0, 32'(o_src[0]), 32'd2);
    md[0] = 1'b1;
    md[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr_src", 0, 32'(o_src[0]), 32'(i % 4));
      chk("rr_valid", 0, 32'(o_v[0]), 32'd1);
    end
    dv[1] = '0;
    cyc();
    yr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", 0, 32'(o_dr[0]), 32'd0);
      cyc();
    end
    yr[0] = 1'b1;
    cyc();
    dv[0] = '0;
    dv[1] = 4'b0011;
    #1;
    chk("sparse_ready", 1, 32'(o_dr[1]), 32'h1);
    cyc();
    chk("sparse_src", 1, 32'(o_src[1]), 32'd0);
    dv[1] = 4'b0111;
    #1;
    chk("ptr_after_wrap", 1, 32'(o_dr[1]), 32'h2);
    cyc();
    md[1] = 1'b0;
    ss[1] = 2'd3;
    #1;
    chk("oob_select", 1, 32'(o_dr[1]), 32'd0);
    cyc();
    dv[0] = 4'hf;
    cyc();
    yr[0] = 1'b0;
    cyc();
    md[0] = 1'b0;
    ss[0] = 2'd1;
    cyc();
    yr[0] = 1'b1;
    cyc();
    md[0] = 1'b1;
    cyc();
    yr[0] = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_mid_valid", 0, 32'(o_v[0]), 32'd0);
    chk("rst_mid_y", 0, 32'(o_y[0]), 32'd0);
    rst = 1'b0;
    yr[0] = 1'b1;
    cyc();
    chk("rst_ptr", 0, 32'(o_src[0]), 32'd0);
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) dd[k][i] = 16'($urandom);
        dv[k] = 4'($urandom);
        md[k] = ($urandom_range(0, 3) != 0);
        ss[k] = 2'($urandom);
        yr[k] = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arb_muxn.md
# arb_muxn

Registered N-channel word multiplexer with a valid/ready handshake on every input and on the output. It generalises the combinational mux2/mux4 tree to any channel count and width, and adds two modes: a fixed-select mode, where the select input chooses the channel, and a round-robin arbitration mode. It sits between multiple word producers and one consumer, and provides one register stage of buffering with full throughput.

## Interface
Parameters:
- `WORD_SIZE`, default 16: data width per channel.
- `N`, default 4: channel count; must be ≥ 2 and need not be a power of 2.
- `SEL_W`, default `$clog2(N)`: derived localparam giving the select and source-index width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `d`  in  N*WORD_SIZE  packed channel data; channel i occupies `d[i*WORD_SIZE +: WORD_SIZE]`.
- `d_valid`  in  N  per-channel valid.
- `d_ready`  out  N  per-channel ready; one-hot or all zero.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `s`  in  SEL_W  channel select; used only when `mode`=0.
- `y`  out  WORD_SIZE  registered output word.
- `y_valid`  out  1  output holds a word.
- `y_ready`  in  1  consumer accepts the word.
- `y_src`  out  SEL_W  index of the channel that supplied `y`.

## Operation
- Output register fields: `y`, `y_src`, `y_valid`. Round-robin pointer: `ptr` (SEL_W bits, range 0..N-1).
- `load_en = !y_valid || y_ready`. This is combinational and gives full throughput with no bubble.
- Grant, combinational:
  - `mode`=0: grant channel `s` if `s < N` and `d_valid[s]`. Otherwise no grant (an out-of-range `s` grants nothing).
  - `mode`=1: grant the first i with `d_valid[i]`, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
- `d_ready[i] = load_en && grant[i]`. At most one bit is set. `d_ready` never depends on `d_valid` of other channels beyond grant selection.
- A transfer on channel g happens when `d_valid[g] && d_ready[g]`. On that edge: `y <= d[g]`, `y_src <= g`, `y_valid <= 1`.
- If `load_en` is set and there is no grant, then `y_valid <= 0`, and `y` and `y_src` hold their values.
- If `y_valid && !y_ready`: `y`, `y_src` and `y_valid` are held stable, and all `d_ready` are 0.
- Pointer: on a transfer with `mode`=1, `ptr <= (g == N-1) ? 0 : g+1`. Pointer wrap is explicit and does not rely on power-of-2 overflow. With `mode`=0 or no transfer, `ptr` holds.
- `mode` and `s` are sampled each cycle. A change takes effect in the same cycle's grant and never corrupts a word already held in the output register.
- Reset, synchronous: `y`=0, `y_src`=0, `y_valid`=0, `ptr`=0. `d_ready` is 0 during any cycle where `reset`=1. Reset asserted mid-stall drops the held word.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on `y` with `y_valid`=1 after edge k.
- Throughput is 1 word per cycle while `y_ready`=1.
- The path from `y_ready` to `d_ready` is combinational. This is permitted, and the consumer must not close a combinational loop from `d_ready` back to `y_ready`.
- Round-robin fairness: with all N channels continuously valid, each channel is granted exactly once every N transfers.
- Worst-case wait for a continuously valid channel in round-robin mode is N-1 transfers.

## Structure
- Shared package `arb_pkg`:
  - `MODE_FIXED` = 1'b0 and `MODE_RR` = 1'b1.
  - A function for next-pointer wrap, `ptr_inc(g, N)`.
- One natural sub-module, `rr_pick`: combinational, parametrised by N. Inputs are `req[N-1:0]` and `ptr`. Outputs are the one-hot `gnt` and the binary index `gnt_idx`, plus `any`. It is implemented as a rotate, then a fixed-priority pick, then an un-rotate.
- The top module holds the fixed-mode decode, the handshake logic, the output register and `ptr`.

## Test plan
1. Reset and fixed select. N=4, WORD_SIZE=16. Hold `reset` for 2 cycles, checking `y_valid`=0 and `d_ready`=0. Then `mode`=0, `s`=2, `d_valid`=4'b1111, channel i data = 16'h1000+i, `y_ready`=1. Required: `d_ready`=4'b0100; next cycle `y`=16'h1002, `y_src`=2.
2. Round-robin fairness. `mode`=1, all channels valid, `y_ready`=1 for 8 cycles. Required: `y_src` sequence 0,1,2,3,0,1,2,3 with `y_valid` held at 1 throughout.
3. Backpressure. Drive a word, then set `y_ready`=0 for 3 cycles. Required: `y`, `y_src` and `y_valid`=1 stable and `d_ready`=0 during the stall. On release, the next word loads in the same cycle, with no bubble.
4. Sparse requests and wrap. N=3, `mode`=1, `ptr`=2, `d_valid`=3'b011. Required: channel 0 granted, then `ptr`=1. With N=3, `s`=3 in fixed mode gives `d_ready`=0.
5. Mode switch and mid-operation reset. Switch `mode` 1→0 while `y_valid`=1 and stalled. Required: the held word is unchanged, and `ptr` is frozen after the switch. Asserting `reset` while `y_valid`=1 gives `y_valid`=0, `y`=0 and `ptr`=0 on the next cycle.
